// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction fetch bridge: bus widths,
// the NOP/zero words and the fetch FSM encoding.
package inst_fetch_bridge_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = 32'h0;
  localparam logic [InstBus-1:0] NopInst  = 32'h0;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_BUSY = 1'b1
  } fetch_state_e;

  // A fetch PC is usable only when it points at a whole instruction word.
  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// Request/acknowledge instruction bus between the fetch bridge (master)
// and the instruction memory system (slave). One read outstanding at a time.
interface inst_fetch_bridge_if;
  import inst_fetch_bridge_pkg::*;

  logic                   req;
  logic [InstAddrBus-1:0] addr;
  logic                   ack;
  logic [InstBus-1:0]     rdata;
  logic                   err;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata,
    output err
  );

endinterface

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns the core's single-cycle ROM port into
// variable-latency bus reads through a one-entry fetch buffer. Stalls the
// core while the requested PC is not in the buffer, and turns bus errors,
// timeouts and misaligned PCs into a NOP plus a one-cycle error pulse.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [InstAddrBus-1:0] rom_addr_i,
  output logic [InstBus-1:0]     rom_data_o,
  output logic                   stall_req_o,
  inst_fetch_bridge_if.master    bus,
  output logic                   fetch_err_o,
  output logic [InstAddrBus-1:0] err_addr_o
);

  // A zero timeout disables the abort; keep the counter at least one bit wide.
  localparam int CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  fetch_state_e           state_q, state_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [InstAddrBus-1:0] buf_addr_q, buf_addr_d;
  logic [InstBus-1:0]     buf_data_q, buf_data_d;
  logic                   bus_req_q, bus_req_d;
  logic [InstAddrBus-1:0] bus_addr_q, bus_addr_d;
  logic                   fetch_err_q, fetch_err_d;
  logic [InstAddrBus-1:0] err_addr_q, err_addr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic hit;
  logic timeoutHit;

  assign hit        = buf_valid_q && (buf_addr_q == rom_addr_i);
  assign timeoutHit = TimeoutEn && (cnt_q == CntMax);

  assign rom_data_o  = hit ? buf_data_q : ZeroWord;
  assign stall_req_o = rom_ce_i && !hit;

  assign bus.req     = bus_req_q;
  assign bus.addr    = bus_addr_q;
  assign fetch_err_o = fetch_err_q;
  assign err_addr_o  = err_addr_q;

  // Next-state logic: start fetches on a miss in IDLE, retire them in BUSY
  // (error beats ack, so a simultaneous ack+err still yields an error fill).
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    fetch_err_d = 1'b0;
    err_addr_d  = err_addr_q;
    cnt_d       = cnt_q;

    case (state_q)
      FETCH_IDLE: begin
        if (rom_ce_i && !hit) begin
          if (isWordAligned(rom_addr_i[1:0])) begin
            state_d    = FETCH_BUSY;
            bus_req_d  = 1'b1;
            bus_addr_d = rom_addr_i;
            cnt_d      = '0;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = rom_addr_i;
            buf_data_d  = NopInst;
            fetch_err_d = 1'b1;
            err_addr_d  = rom_addr_i;
          end
        end
      end

      FETCH_BUSY: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bus.err || timeoutHit) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = bus_addr_q;
          buf_data_d  = NopInst;
          fetch_err_d = 1'b1;
          err_addr_d  = bus_addr_q;
          bus_req_d   = 1'b0;
          state_d     = FETCH_IDLE;
        end else if (bus.ack) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = bus_addr_q;
          buf_data_d  = bus.rdata;
          bus_req_d   = 1'b0;
          state_d     = FETCH_IDLE;
        end
      end

      default: begin
        state_d   = FETCH_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // Register FSM state, buffer and all bus/error outputs; reset abandons any read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= ZeroWord;
      buf_data_q  <= ZeroWord;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= ZeroWord;
      fetch_err_q <= 1'b0;
      err_addr_q  <= ZeroWord;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      fetch_err_q <= fetch_err_d;
      err_addr_q  <= err_addr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge. Expected bus requests and
// error pulses are queued as fetches are issued and retired by a monitor
// that runs every cycle; core-side results are checked per fetch.
module tb_inst_fetch_bridge;
  import inst_fetch_bridge_pkg::*;

  localparam int MODE_ACK  = 0;
  localparam int MODE_NONE = 1;
  localparam int MODE_ERR  = 2;
  localparam int MODE_BOTH = 3;

  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stall_req_o;
  logic        fetch_err_o;
  logic [31:0] err_addr_o;

  inst_fetch_bridge_if bus ();

  inst_fetch_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .stall_req_o(stall_req_o),
    .bus        (bus),
    .fetch_err_o(fetch_err_o),
    .err_addr_o (err_addr_o)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] expReqQ[$];
  logic [31:0] expErrQ[$];
  logic [31:0] curReqAddr = 32'h0;
  logic        reqPrev = 1'b0;
  int          reqHighCycles = 0;
  int          errPulses = 0;

  int slaveMode = MODE_ACK;
  int slaveAckAt = 1;
  int slaveCnt = 0;
  bit strayAck = 1'b0;

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a wedged design still ends with a failure line.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction image served by the slave model.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h0) ? 32'h34011100 : (32'h3C000000 | a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic [31:0] pc);
    rom_ce_i   = ce;
    rom_addr_i = pc;
  endtask

  // One clock cycle: drive core and slave inputs at the falling edge, then
  // sample and retire scoreboard entries 1 ns later.
  task automatic cycle(input logic ce, input logic [31:0] pc);
    @(negedge clk);
    applyStimulus(ce, pc);
    bus.ack   = 1'b0;
    bus.err   = 1'b0;
    bus.rdata = 32'h0;
    if (strayAck) begin
      bus.ack   = 1'b1;
      bus.rdata = 32'hDEADBEEF;
    end else if (bus.req) begin
      slaveCnt++;
      if (slaveCnt == slaveAckAt) begin
        if (slaveMode == MODE_ACK || slaveMode == MODE_BOTH) begin
          bus.ack   = 1'b1;
          bus.rdata = memWord(bus.addr);
        end
        if (slaveMode == MODE_ERR || slaveMode == MODE_BOTH) begin
          bus.err = 1'b1;
        end
      end
    end else begin
      slaveCnt = 0;
    end
    #1;
    if (bus.req) begin
      reqHighCycles++;
      if (!reqPrev) begin
        checkOutput("req_expected", 32'(expReqQ.size() != 0), 32'd1);
        if (expReqQ.size() != 0) begin
          curReqAddr = expReqQ.pop_front();
          checkOutput("req_addr", bus.addr, curReqAddr);
        end
      end else if (bus.addr !== curReqAddr) begin
        checkOutput("req_addr_stable", bus.addr, curReqAddr);
      end
    end
    reqPrev = bus.req;
    if (fetch_err_o) begin
      errPulses++;
      checkOutput("err_expected", 32'(expErrQ.size() != 0), 32'd1);
      if (expErrQ.size() != 0) begin
        checkOutput("err_addr", err_addr_o, expErrQ.pop_front());
      end
    end
  endtask

  // Hold a PC until the stall clears; check stall count and delivered word.
  task automatic runFetch(input string tag, input logic [31:0] pc,
                          input int stallsExp, input logic [31:0] dataExp);
    int stalls = 0;
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      cycle(1'b1, pc);
      if (stall_req_o) begin
        stalls++;
        if (rom_data_o !== 32'h0) checkOutput({tag, "_stall_data"}, rom_data_o, 32'h0);
      end else begin
        done = 1'b1;
      end
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_stalls"}, 32'(stalls), 32'(stallsExp));
    checkOutput({tag, "_data"}, rom_data_o, dataExp);
  endtask

  // Directed scenarios run in order from a single stimulus thread.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0);
    bus.ack = 1'b0;
    bus.err = 1'b0;
    bus.rdata = 32'h0;

    // Reset state, with stall tracking rom_ce_i while nothing is buffered.
    cycle(1'b0, 32'h0);
    checkOutput("rst_rom_data", rom_data_o, 32'h0);
    checkOutput("rst_stall_ce0", 32'(stall_req_o), 32'd0);
    checkOutput("rst_bus_req", 32'(bus.req), 32'd0);
    checkOutput("rst_bus_addr", bus.addr, 32'h0);
    checkOutput("rst_fetch_err", 32'(fetch_err_o), 32'd0);
    checkOutput("rst_err_addr", err_addr_o, 32'h0);
    cycle(1'b1, 32'h0);
    checkOutput("rst_stall_ce1", 32'(stall_req_o), 32'd1);
    cycle(1'b0, 32'h0);
    rst = 1'b0;

    // Cold fetch, ack on the third request cycle.
    slaveMode = MODE_ACK;
    slaveAckAt = 3;
    expReqQ.push_back(32'h0);
    runFetch("cold", 32'h0, 4, 32'h34011100);
    reqHighCycles = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h0);
      checkOutput("rehit_stall", 32'(stall_req_o), 32'd0);
      checkOutput("rehit_data", rom_data_o, 32'h34011100);
    end
    checkOutput("rehit_no_req", 32'(reqHighCycles), 32'd0);

    // Sequential PCs with same-cycle ack: minimum two-cycle miss penalty.
    rst = 1'b1;
    cycle(1'b0, 32'h0);
    rst = 1'b0;
    slaveAckAt = 1;
    for (int i = 0; i < 3; i++) begin
      expReqQ.push_back(32'(i * 4));
      runFetch("seq", 32'(i * 4), 2, memWord(32'(i * 4)));
    end

    // Timeout on a silent slave: five request cycles, then NOP and error.
    slaveMode = MODE_NONE;
    reqHighCycles = 0;
    errPulses = 0;
    expReqQ.push_back(32'h100);
    expErrQ.push_back(32'h100);
    runFetch("tmo", 32'h100, 6, 32'h0);
    checkOutput("tmo_req_cycles", 32'(reqHighCycles), 32'd5);
    cycle(1'b1, 32'h100);
    cycle(1'b1, 32'h100);
    checkOutput("tmo_err_once", 32'(errPulses), 32'd1);

    // Misaligned PC: no bus traffic, one stall, NOP and error pulse.
    reqHighCycles = 0;
    expErrQ.push_back(32'h102);
    runFetch("misal", 32'h102, 1, 32'h0);
    checkOutput("misal_err_addr", err_addr_o, 32'h102);
    checkOutput("misal_no_req", 32'(reqHighCycles), 32'd0);

    // Ack and err together: error takes priority.
    slaveMode = MODE_BOTH;
    slaveAckAt = 1;
    expReqQ.push_back(32'h200);
    expErrQ.push_back(32'h200);
    runFetch("ackerr", 32'h200, 2, 32'h0);
    checkOutput("ackerr_err_addr", err_addr_o, 32'h200);

    // Branch while BUSY: old PC completes, then a fresh request for the new PC.
    slaveMode = MODE_ACK;
    slaveAckAt = 3;
    expReqQ.push_back(32'h10);
    expReqQ.push_back(32'h40);
    cycle(1'b1, 32'h10);
    cycle(1'b1, 32'h10);
    runFetch("branch", 32'h40, 6, memWord(32'h40));

    // Reset with a request outstanding, then a stray ack that must be ignored.
    slaveMode = MODE_NONE;
    expReqQ.push_back(32'h300);
    cycle(1'b1, 32'h300);
    cycle(1'b1, 32'h300);
    checkOutput("rstmid_req_up", 32'(bus.req), 32'd1);
    rst = 1'b1;
    cycle(1'b0, 32'h40);
    checkOutput("rstmid_req_drop", 32'(bus.req), 32'd0);
    checkOutput("rstmid_buf_inval", rom_data_o, 32'h0);
    rst = 1'b0;
    strayAck = 1'b1;
    cycle(1'b0, 32'h0);
    strayAck = 1'b0;
    cycle(1'b0, 32'h0);
    checkOutput("stray_ignored", rom_data_o, 32'h0);
    slaveMode = MODE_ACK;
    slaveAckAt = 1;
    expReqQ.push_back(32'h40);
    runFetch("refetch", 32'h40, 2, memWord(32'h40));

    checkOutput("req_queue_empty", 32'(expReqQ.size()), 32'd0);
    checkOutput("err_queue_empty", 32'(expErrQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
